// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset PC, queue depth and the
// layout of one fetch-queue entry.
package inst_fetch_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [ADDR_BUS-1:0] INIT_PC = 32'hbfc0_0000;
    localparam int FETCH_QUEUE_DEPTH = 2;

    // One buffered fetch: exception flag, fetch address and instruction word.
    typedef struct packed {
        logic                adel;
        logic [ADDR_BUS-1:0] pc;
        logic [DATA_BUS-1:0] inst;
    } fetch_entry_t;

    // A fetch address is misaligned when it is not on a word boundary.
    function automatic logic pc_misaligned(input logic [ADDR_BUS-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular fetch FIFO with push, pop and clear. Pointers wrap naturally
// because DEPTH is a power of two; the count has one extra bit to tell
// full from empty.
module inst_fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop from an empty queue is ignored; a push into a full queue only
    // happens when the head leaves in the same cycle. Clear wins over both.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    // Next-state pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: the storage array is deliberately not reset; the count alone
    // decides which entries are meaningful, and consumers gate on empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM, and
// buffers fetched words for decode. Redirects and flushes reload the PC and
// drop everything queued.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC    = INIT_PC,
    parameter int                  QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ADDR_BUS-1:0]    flush_pc,
    input  logic                   redirect_en,
    input  logic [ADDR_BUS-1:0]    redirect_pc,
    output logic                   rom_en,
    output logic [MEM_SEL_BUS-1:0] rom_write_en,
    output logic [ADDR_BUS-1:0]    rom_addr,
    output logic [DATA_BUS-1:0]    rom_write_data,
    input  logic [DATA_BUS-1:0]    rom_read_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [ADDR_BUS-1:0]    id_pc,
    output logic [DATA_BUS-1:0]    id_inst,
    output logic                   id_adel
);

    logic [ADDR_BUS-1:0] pc_q, pc_d;

    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         q_full;
    logic         q_empty;
    logic         pop;
    logic         clear;
    logic         misaligned;

    // Fetch never writes the ROM.
    assign rom_write_en   = '0;
    assign rom_write_data = '0;

    assign pop   = id_valid && id_ready;
    assign clear = flush || redirect_en;

    // A slot is available when the queue has room or the head leaves now.
    assign rom_en   = rst && !clear && (!q_full || pop);
    assign rom_addr = pc_q;

    // Misaligned fetches are queued with the exception flag and no word;
    // the later stage raises the exception and flushes.
    assign misaligned      = pc_misaligned(pc_q);
    assign push_entry.adel = misaligned;
    assign push_entry.pc   = pc_q;
    assign push_entry.inst = misaligned ? '0 : rom_read_data;

    inst_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst),
        .clear_i     (clear),
        .push_i      (rom_en),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Decode sees zeros whenever the queue is empty.
    assign id_valid = !q_empty;
    assign id_pc    = id_valid ? head.pc   : '0;
    assign id_inst  = id_valid ? head.inst : '0;
    assign id_adel  = id_valid && head.adel;

    // Next PC: flush beats redirect, which beats sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (flush)            pc_d = flush_pc;
        else if (redirect_en) pc_d = redirect_pc;
        else if (rom_en)      pc_d = pc_q + 32'd4;
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a driver/reference model decides each cycle what the
// fetch stage must do and queues expected entries; a separate monitor checks
// the ROM port and pops/compares entries as decode consumes them.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic [31:0] rom_read_data;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]  m_pc  = INIT_PC;
    int           m_occ = 0;
    bit           exp_rom_en = 1'b0;
    logic [31:0]  exp_rom_addr = '0;
    bit           m_clr = 1'b0;
    bit           stage_v = 1'b0;
    fetch_entry_t stage;
    fetch_entry_t sb [$];

    always #5 clk = ~clk;

    // ROM contents as a pure function of the word address.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf ^ (a << 3);
    endfunction

    assign rom_read_data = rom_en ? rom_fn(rom_addr) : 32'h0;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .rom_en         (rom_en),
        .rom_write_en   (rom_write_en),
        .rom_addr       (rom_addr),
        .rom_write_data (rom_write_data),
        .rom_read_data  (rom_read_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_adel        (id_adel)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the reference model's decision.
    // Inputs change on the falling edge; the model runs 1 unit later, the
    // monitor compares 2 units later, and the model commits 3 units later.
    task automatic step(input bit rst_v, input bit fl, input logic [31:0] fpc,
                        input bit rd, input logic [31:0] rpc, input bit rdy);
        bit pop_m;
        bit fetch_m;
        @(negedge clk);
        rst         = rst_v;
        flush       = fl;
        flush_pc    = fpc;
        redirect_en = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        #1;
        stage_v = 1'b0;
        if (!rst_v) begin
            // Reset empties the stage immediately and suppresses fetching.
            sb.delete();
            m_occ      = 0;
            m_pc       = INIT_PC;
            exp_rom_en = 1'b0;
            m_clr      = 1'b1;
        end else begin
            pop_m        = (m_occ > 0) && rdy;
            m_clr        = fl || rd;
            fetch_m      = !m_clr && ((m_occ < DEPTH) || pop_m);
            exp_rom_en   = fetch_m;
            exp_rom_addr = m_pc;
            if (fetch_m) begin
                stage.adel = (m_pc % 4) != 0;
                stage.pc   = m_pc;
                stage.inst = stage.adel ? 32'h0 : rom_fn(m_pc);
                stage_v    = 1'b1;
            end
            if (m_clr) begin
                m_occ = 0;
                m_pc  = fl ? fpc : rpc;
            end else begin
                m_occ = m_occ + int'(fetch_m) - int'(pop_m);
                if (fetch_m) m_pc = m_pc + 32'd4;
            end
        end
        #2;
        if (m_clr) sb.delete();
        if (stage_v) sb.push_back(stage);
    endtask

    // Monitor: ROM port against the model, head entry against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("rom_en", 64'(rom_en), 64'(exp_rom_en));
            if (exp_rom_en) check("rom_addr", 64'(rom_addr), 64'(exp_rom_addr));
            check("id_valid", 64'(id_valid), 64'(sb.size() > 0));
            if (id_valid && sb.size() > 0) begin
                check("id_pc",   64'(id_pc),   64'(sb[0].pc));
                check("id_inst", 64'(id_inst), 64'(sb[0].inst));
                check("id_adel", 64'(id_adel), 64'(sb[0].adel));
                if (id_ready && !m_clr) void'(sb.pop_front());
            end else if (!id_valid) begin
                check("idle_pc",   64'(id_pc),   64'h0);
                check("idle_inst", 64'(id_inst), 64'h0);
                check("idle_adel", 64'(id_adel), 64'h0);
            end
        end
    end

    initial begin
        int fetches;
        logic [31:0] tgt;

        // Reset held, then released with decode always ready.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rom_write_en", 64'(rom_write_en), 64'h0);
        check("rom_write_data", 64'(rom_write_data), 64'h0);
        repeat (6) step(1, 0, 0, 0, 0, 1);

        // Fresh reset, decode stalled: exactly two fetches, PC parks at +8.
        step(0, 0, 0, 0, 0, 0);
        fetches = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (rom_en) fetches++;
        end
        check("stall_fetches", 64'(fetches), 64'd2);
        check("stall_addr", 64'(rom_addr), 64'hbfc0_0008);
        // Draining, then full-queue streaming with push and pop together.
        repeat (8) step(1, 0, 0, 0, 0, 1);

        // Redirect while full.
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'hbfc0_0100, 1);
        repeat (4) step(1, 0, 0, 0, 0, 1);

        // Flush and redirect together: flush target wins.
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'hbfc0_0380, 1, 32'hbfc0_0100, 1);
        repeat (4) step(1, 0, 0, 0, 0, 1);

        // Misaligned redirect target, then a PC that wraps past 2^32.
        step(1, 0, 0, 1, 32'hbfc0_0102, 1);
        repeat (4) step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 32'hffff_fff8, 1);
        repeat (5) step(1, 0, 0, 0, 0, 1);

        // Reset pulse mid-stream with a non-empty queue.
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 199) == 0)
                step(0, 0, 0, 0, 0, 1);
            else
                step(1, $urandom_range(0, 29) == 0, tgt,
                     $urandom_range(0, 19) == 0, tgt ^ 32'h0000_0040,
                     $urandom_range(0, 9) < 7);
        end

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
